// File: rtl/mmc1_serial_writer_if.sv
// Host command handshake plus the CPU-side cartridge bus driven by mmc1_serial_writer.
interface mmc1_serial_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_reset;
    logic [1:0] cmd_reg;
    logic [4:0] cmd_data;
    logic       busy;
    logic       done;
    logic       CPU_M2;
    logic       nCPU_ROMSEL;
    logic       nCPU_RW;
    logic       CPU_A14;
    logic       CPU_A13;
    logic       CPU_D0;
    logic       CPU_D7;

    modport master (
        input  cmd_valid, cmd_reset, cmd_reg, cmd_data,
        output cmd_ready, busy, done,
        output CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7
    );

    modport slave (
        output cmd_valid, cmd_reset, cmd_reg, cmd_data,
        input  cmd_ready, busy, done,
        input  CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7
    );
endinterface

// File: rtl/mmc1_serial_writer.sv
// MMC1 serial register writer: turns one host command into five LSB-first D0 writes
// (or a single D7 shift-reset write) on a free-running, CLK-derived M2 bus.
module mmc1_serial_writer #(
    parameter int HALF_CLKS  = 6,
    parameter int ROMSEL_DLY = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    mmc1_serial_writer_if.master bus
);
    localparam int PH_W  = $clog2(HALF_CLKS);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_CLKS - 1);
    localparam logic [PH_W-1:0]  PH_STRB  = PH_W'(ROMSEL_DLY);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, WRITE, GAP, FIN} state_t;

    state_t           state;
    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  ph_nx;
    logic             half;
    logic             half_nx;
    logic             wrap_to_low;
    logic [2:0]       bit_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             rst_cmd;
    logic [1:0]       reg_sel;
    logic [4:0]       data_sr;

    // Outputs are decided from the phase the next edge lands in, so bus pins change
    // on the same edge as M2.
    always_comb begin
        ph_nx       = (ph == PH_LAST) ? '0 : ph + 1'b1;
        half_nx     = (ph == PH_LAST) ? ~half : half;
        wrap_to_low = (ph == PH_LAST) && half;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ph   <= '0;
            half <= 1'b0;
        end else begin
            ph   <= ph_nx;
            half <= half_nx;
        end
    end

    assign bus.CPU_M2 = half;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            bit_idx         <= '0;
            gap_cnt         <= '0;
            bus.cmd_ready   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.nCPU_ROMSEL <= 1'b1;
            bus.nCPU_RW     <= 1'b1;
            bus.CPU_A14     <= 1'b0;
            bus.CPU_A13     <= 1'b0;
            bus.CPU_D0      <= 1'b0;
            bus.CPU_D7      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        rst_cmd       <= bus.cmd_reset;
                        reg_sel       <= bus.cmd_reset ? 2'b00 : bus.cmd_reg;
                        data_sr       <= bus.cmd_reset ? 5'b00000 : bus.cmd_data;
                        bit_idx       <= '0;
                        gap_cnt       <= '0;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (wrap_to_low) begin
                        bus.nCPU_RW <= 1'b0;
                        bus.CPU_A14 <= reg_sel[1];
                        bus.CPU_A13 <= reg_sel[0];
                        bus.CPU_D0  <= data_sr[0];
                        bus.CPU_D7  <= rst_cmd;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    bus.nCPU_ROMSEL <= !(half_nx && (ph_nx >= PH_STRB));
                    if (wrap_to_low) begin
                        bus.nCPU_ROMSEL <= 1'b1;
                        bus.nCPU_RW     <= 1'b1;
                        bus.CPU_D0      <= 1'b0;
                        bus.CPU_D7      <= 1'b0;
                        data_sr         <= {1'b0, data_sr[4:1]};
                        gap_cnt         <= '0;
                        state           <= GAP;
                    end
                end
                GAP: begin
                    if (wrap_to_low) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            if (rst_cmd || (bit_idx == 3'd4)) begin
                                bus.done <= 1'b1;
                                state    <= FIN;
                            end else begin
                                bit_idx     <= bit_idx + 1'b1;
                                bus.nCPU_RW <= 1'b0;
                                bus.CPU_D0  <= data_sr[0];
                                state       <= WRITE;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                FIN: begin
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Directed bench for mmc1_serial_writer with a loopback MMC1 register model on the CPU bus.
module tb_mmc1_serial_writer;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    mmc1_serial_writer_if bus();

    mmc1_serial_writer #(.HALF_CLKS(6), .ROMSEL_DLY(1), .GAP_CYCLES(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int bad_strobe = 0;
    int bad_edge = 0;
    int cur_len = 0;
    int rw_run = 0;
    int rise_cyc = 0;
    int done_cyc = 0;
    logic prev_romsel = 1'b1;
    int   strb_start [16];
    int   strb_len   [16];
    int   strb_setup [16];
    logic strb_d0    [16];
    logic strb_d7    [16];
    logic strb_a14   [16];
    logic strb_a13   [16];

    logic [4:0] m_ctrl = 5'b0;
    logic [4:0] m_chr0 = 5'b0;
    logic [4:0] m_chr1 = 5'b0;
    logic [4:0] m_prg = 5'b0;
    logic [4:0] m_shift = 5'b0;
    int         m_cnt = 0;

    always @(posedge CLK) cyc++;

    // Bus monitor and MMC1 model; a write is taken when nCPU_ROMSEL falls with nCPU_RW low.
    always @(negedge CLK) begin
        if (bus.nCPU_RW === 1'b0) rw_run++;
        else rw_run = 0;
        if (bus.nCPU_ROMSEL === 1'b0 && (bus.CPU_M2 !== 1'b1 || bus.nCPU_RW !== 1'b0)) bad_strobe++;
        if (prev_romsel === 1'b1 && bus.nCPU_ROMSEL === 1'b0) begin
            if (strobe_cnt < 16) begin
                strb_start[strobe_cnt] = cyc;
                strb_setup[strobe_cnt] = rw_run;
                strb_d0[strobe_cnt]    = bus.CPU_D0;
                strb_d7[strobe_cnt]    = bus.CPU_D7;
                strb_a14[strobe_cnt]   = bus.CPU_A14;
                strb_a13[strobe_cnt]   = bus.CPU_A13;
            end
            strobe_cnt++;
            cur_len = 1;
            if (bus.nCPU_RW === 1'b0) begin
                if (bus.CPU_D7 === 1'b1) begin
                    m_shift = 5'b0;
                    m_cnt   = 0;
                    m_ctrl  = m_ctrl | 5'b01100;
                end else begin
                    m_shift = {bus.CPU_D0, m_shift[4:1]};
                    m_cnt++;
                    if (m_cnt == 5) begin
                        case ({bus.CPU_A14, bus.CPU_A13})
                            2'b00:   m_ctrl = m_shift;
                            2'b01:   m_chr0 = m_shift;
                            2'b10:   m_chr1 = m_shift;
                            default: m_prg  = m_shift;
                        endcase
                        m_shift = 5'b0;
                        m_cnt   = 0;
                    end
                end
            end
        end else if (bus.nCPU_ROMSEL === 1'b0) begin
            cur_len++;
        end
        if (prev_romsel === 1'b0 && bus.nCPU_ROMSEL === 1'b1) begin
            if (strobe_cnt >= 1 && strobe_cnt <= 16) strb_len[strobe_cnt-1] = cur_len;
            if (bus.CPU_M2 !== 1'b0 || bus.nCPU_RW !== 1'b1) bad_edge++;
            rise_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_romsel = bus.nCPU_ROMSEL;
    end

    task automatic send(input logic r, input logic [1:0] g, input logic [4:0] d, output bit ok);
        @(negedge CLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_reset = r;
        bus.cmd_reg   = g;
        bus.cmd_data  = d;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_reset = 1'b0;
        bus.cmd_reg   = ~g;
        bus.cmd_data  = ~d;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int bad;
        bus.cmd_valid = 1'b0;
        bus.cmd_reset = 1'b0;
        bus.cmd_reg   = 2'b00;
        bus.cmd_data  = 5'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++; if (bus.CPU_M2 !== 1'b0) begin errors++; $display("FAIL rst_m2 got=%b want=0", bus.CPU_M2); end
        checks++; if (bus.nCPU_ROMSEL !== 1'b1) begin errors++; $display("FAIL rst_romsel got=%b want=1", bus.nCPU_ROMSEL); end
        checks++; if (bus.nCPU_RW !== 1'b1) begin errors++; $display("FAIL rst_rw got=%b want=1", bus.nCPU_RW); end
        checks++; if ({bus.CPU_A14, bus.CPU_A13, bus.CPU_D0, bus.CPU_D7} !== 4'b0000) begin
            errors++; $display("FAIL rst_addr_data got=%b want=0000", {bus.CPU_A14, bus.CPU_A13, bus.CPU_D0, bus.CPU_D7}); end
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got=%b want=00", {bus.busy, bus.done}); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", bus.cmd_ready); end
        RST = 1'b0;
        bad = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got=%b want=1", bus.cmd_ready); end
            end
            if (bus.CPU_M2 !== 1'((n / 6) % 2)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL m2_pattern wrong_samples=%0d want=0", bad); end
    endtask

    task automatic test_data_write;
        bit ok;
        int bad_len, bad_gap, bad_addr, bad_setup;
        logic [4:0] d0_seq;
        strobe_cnt = 0;
        done_cnt = 0;
        send(1'b0, 2'b11, 5'b10110, ok);
        checks++; if (!ok) begin errors++; $display("FAIL data_accept got=timeout want=accept"); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL data_done got=timeout want=done"); end
        repeat (30) @(negedge CLK);
        checks++; if (strobe_cnt != 5) begin errors++; $display("FAIL data_strobes got=%0d want=5", strobe_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL data_done_pulses got=%0d want=1", done_cnt); end
        bad_len = 0; bad_gap = 0; bad_addr = 0; bad_setup = 0; d0_seq = 5'b0;
        for (int i = 0; i < 5; i++) begin
            d0_seq[i] = strb_d0[i];
            if (strb_len[i] != 5) bad_len++;
            if (strb_setup[i] != 8) bad_setup++;
            if ({strb_a14[i], strb_a13[i], strb_d7[i]} !== 3'b110) bad_addr++;
            if (i > 0 && (strb_start[i] - strb_start[i-1]) != 36) bad_gap++;
        end
        checks++; if (d0_seq !== 5'b10110) begin errors++; $display("FAIL data_d0_seq got=%b want=10110", d0_seq); end
        checks++; if (bad_len != 0) begin errors++; $display("FAIL data_strobe_len bad=%0d want=0 (first len %0d want 5)", bad_len, strb_len[0]); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL data_strobe_spacing bad=%0d want=0 (first gap %0d want 36)", bad_gap, strb_start[1] - strb_start[0]); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL data_a14_a13_d7 bad=%0d want=0", bad_addr); end
        checks++; if (bad_setup != 0) begin errors++; $display("FAIL data_setup bad=%0d want=0 (first %0d want 8)", bad_setup, strb_setup[0]); end
        checks++; if (m_prg !== 5'b10110) begin errors++; $display("FAIL data_model_prg got=%b want=10110", m_prg); end
    endtask

    task automatic test_reset_cmd;
        bit ok;
        strobe_cnt = 0;
        done_cnt = 0;
        send(1'b1, 2'b11, 5'b11111, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rcmd_accept got=timeout want=accept"); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rcmd_done got=timeout want=done"); end
        repeat (30) @(negedge CLK);
        checks++; if (strobe_cnt != 1) begin errors++; $display("FAIL rcmd_strobes got=%0d want=1", strobe_cnt); end
        checks++; if ({strb_d7[0], strb_a14[0], strb_a13[0], strb_d0[0]} !== 4'b1000) begin
            errors++; $display("FAIL rcmd_bus got=%b want=1000", {strb_d7[0], strb_a14[0], strb_a13[0], strb_d0[0]}); end
        checks++; if (done_cyc - rise_cyc != 24) begin errors++; $display("FAIL rcmd_gap got=%0d want=24", done_cyc - rise_cyc); end
        checks++; if (m_cnt != 0) begin errors++; $display("FAIL rcmd_model_shift got=%0d want=0", m_cnt); end
    endtask

    task automatic test_back_to_back;
        bit ok, got_done;
        int bad;
        strobe_cnt = 0;
        done_cnt = 0;
        @(negedge CLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_reset = 1'b0;
        bus.cmd_reg   = 2'b01;
        bus.cmd_data  = 5'b00011;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_accept got=timeout want=accept"); end
        @(posedge CLK);
        #1;
        bus.cmd_reg  = 2'b10;
        bus.cmd_data = 5'b10101;
        bad = 0;
        got_done = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            if (bus.done === 1'b1) begin got_done = 1'b1; break; end
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        checks++; if (!got_done) begin errors++; $display("FAIL b2b_first_done got=timeout want=done"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ready_while_busy samples=%0d want=0", bad); end
        @(negedge CLK);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done got=%b want=1", bus.cmd_ready); end
        @(posedge CLK);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge CLK);
        checks++; if ({bus.busy, bus.cmd_ready} !== 2'b10) begin errors++; $display("FAIL b2b_second_accept got=%b want=10", {bus.busy, bus.cmd_ready}); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done got=timeout want=done"); end
        repeat (5) @(negedge CLK);
        checks++; if (strobe_cnt != 10) begin errors++; $display("FAIL b2b_strobes got=%0d want=10", strobe_cnt); end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d want=2", done_cnt); end
        checks++; if (m_chr0 !== 5'b00011) begin errors++; $display("FAIL b2b_model_chr0 got=%b want=00011", m_chr0); end
        checks++; if (m_chr1 !== 5'b10101) begin errors++; $display("FAIL b2b_model_chr1 got=%b want=10101", m_chr1); end
    endtask

    task automatic test_mid_reset;
        bit ok, hit;
        strobe_cnt = 0;
        done_cnt = 0;
        send(1'b0, 2'b01, 5'b11111, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_accept got=timeout want=accept"); end
        hit = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            if (strobe_cnt >= 3) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_third_strobe got=timeout want=strobe"); end
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (bus.nCPU_ROMSEL !== 1'b1) begin errors++; $display("FAIL midrst_romsel got=%b want=1", bus.nCPU_ROMSEL); end
        checks++; if (bus.nCPU_RW !== 1'b1) begin errors++; $display("FAIL midrst_rw got=%b want=1", bus.nCPU_RW); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        @(negedge CLK);
        RST = 1'b0;
        repeat (300) @(negedge CLK);
        checks++; if (strobe_cnt != 3 || done_cnt != 0) begin
            errors++; $display("FAIL midrst_quiet strobes=%0d dones=%0d want=3,0", strobe_cnt, done_cnt); end
        checks++; if (m_cnt != 3) begin errors++; $display("FAIL midrst_partial got=%0d want=3", m_cnt); end
        send(1'b1, 2'b00, 5'b00000, ok);
        wait_done(ok);
        send(1'b0, 2'b00, 5'b01111, ok);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_recover_done got=timeout want=done"); end
        checks++; if (m_ctrl !== 5'b01111) begin errors++; $display("FAIL midrst_model_ctrl got=%b want=01111", m_ctrl); end
        checks++; if (m_chr0 !== 5'b00011) begin errors++; $display("FAIL midrst_model_chr0 got=%b want=00011", m_chr0); end
    endtask

    task automatic test_loopback;
        bit ok;
        int fails;
        fails = 0;
        send(1'b0, 2'b00, 5'b01100, ok); wait_done(ok); if (!ok) fails++;
        send(1'b0, 2'b01, 5'b00011, ok); wait_done(ok); if (!ok) fails++;
        send(1'b0, 2'b10, 5'b10101, ok); wait_done(ok); if (!ok) fails++;
        send(1'b0, 2'b11, 5'b00101, ok); wait_done(ok); if (!ok) fails++;
        checks++; if (fails != 0) begin errors++; $display("FAIL loop_done_timeouts got=%0d want=0", fails); end
        checks++; if (m_ctrl !== 5'b01100) begin errors++; $display("FAIL loop_ctrl got=%b want=01100", m_ctrl); end
        checks++; if (m_chr0 !== 5'b00011) begin errors++; $display("FAIL loop_chr0 got=%b want=00011", m_chr0); end
        checks++; if (m_chr1 !== 5'b10101) begin errors++; $display("FAIL loop_chr1 got=%b want=10101", m_chr1); end
        checks++; if (m_prg !== 5'b00101) begin errors++; $display("FAIL loop_prg got=%b want=00101", m_prg); end
        checks++; if (bad_strobe != 0) begin errors++; $display("FAIL loop_strobe_outside_m2_high got=%0d want=0", bad_strobe); end
        checks++; if (bad_edge != 0) begin errors++; $display("FAIL loop_release_not_on_m2_fall got=%0d want=0", bad_edge); end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_reset_cmd();
        test_back_to_back();
        test_mid_reset();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
